// File: rtl/imul_resp_accum.sv
// Batch accumulator on the multiplier response stream: sums every p_len
// products and hands one sum plus an unsigned-overflow flag to the sink.
module imul_resp_accum #(
    parameter int p_nbits = 32,
    parameter int p_len   = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clear,
    input  logic               in_val,
    output logic               in_rdy,
    input  logic [p_nbits-1:0] in_msg,
    output logic               out_val,
    input  logic               out_rdy,
    output logic [p_nbits-1:0] out_msg,
    output logic               out_ovf
);

    localparam int CW = (p_len < 2) ? 1 : $clog2(p_len + 1);
    localparam logic [CW-1:0] LAST = CW'(p_len - 1);

    localparam logic [0:0] ACC  = 1'b0;
    localparam logic [0:0] DONE = 1'b1;

    logic [0:0]         state;
    logic [p_nbits-1:0] sum;
    logic               ovf;
    logic [CW-1:0]      count;

    logic               in_xfer;
    logic               out_xfer;
    logic [p_nbits:0]   sum_ext;

    // Handshake readiness depends only on state, so no val->rdy paths exist.
    assign in_rdy   = (state == ACC);
    assign out_val  = (state == DONE);
    assign out_msg  = sum;
    assign out_ovf  = ovf;

    assign in_xfer  = in_val && in_rdy;
    assign out_xfer = out_val && out_rdy;
    assign sum_ext  = {1'b0, sum} + {1'b0, in_msg};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ACC;
            sum   <= '0;
            ovf   <= 1'b0;
            count <= '0;
        end else if (clear) begin
            // Abort wins over any handshake this cycle; upstream must re-present.
            state <= ACC;
            sum   <= '0;
            ovf   <= 1'b0;
            count <= '0;
        end else begin
            case (state)
                ACC: begin
                    if (in_xfer) begin
                        sum   <= sum_ext[p_nbits-1:0];
                        ovf   <= ovf | sum_ext[p_nbits];
                        count <= count + 1'b1;
                        if (count == LAST) state <= DONE;
                    end
                end
                DONE: begin
                    if (out_xfer) begin
                        state <= ACC;
                        sum   <= '0;
                        ovf   <= 1'b0;
                        count <= '0;
                    end
                end
                default: state <= ACC;
            endcase
        end
    end

endmodule
